// File: rtl/pwm_seq_pkg.sv
// Shared types and defaults for the PWM fade sequencer.
// Channel ramp state encoding plus the default core dimensions.
package pwm_seq_pkg;

  localparam int STATE_W    = 2;
  localparam int DEF_R_SIZE = 8;
  localparam int DEF_NCH    = 3;
  localparam int DEF_RATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    CH_IDLE = 2'd0,
    CH_UP   = 2'd1,
    CH_DOWN = 2'd2
  } chan_state_e;

endpackage

// File: rtl/pwm_seq_chan.sv
// One sequencer channel: holds duty/target/rate and steps duty by one per due period tick.
// Optional triangle "breathing" between 0 and target is compiled in with PWM_SEQ_BREATHE_EN.
module pwm_seq_chan
  import pwm_seq_pkg::*;
#(
  parameter int R_SIZE = DEF_R_SIZE,
  parameter int RATE_W = DEF_RATE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_i,
  input  logic              wr_i,
  input  logic [R_SIZE-1:0] wr_target_i,
  input  logic [RATE_W-1:0] wr_rate_i,
  output logic [R_SIZE-1:0] duty_o,
  output logic              load_o,
  output logic              busy_o
);

  logic [R_SIZE-1:0] cur_q;
  logic [R_SIZE-1:0] target_q;
  logic [RATE_W-1:0] rate_q;
  logic [RATE_W-1:0] rate_cnt_q;
  logic              load_q;
  chan_state_e       state_q;
  logic [R_SIZE-1:0] step_d;

  // A step never wraps: UP only while cur < target, DOWN only while cur > 0.
  assign step_d = (state_q == CH_UP) ? cur_q + R_SIZE'(1) : cur_q - R_SIZE'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q      <= '0;
      target_q   <= '0;
      rate_q     <= '0;
      rate_cnt_q <= '0;
      load_q     <= 1'b0;
      state_q    <= CH_IDLE;
    end else begin
      load_q <= 1'b0;
      if (wr_i) begin
        target_q   <= wr_target_i;
        rate_q     <= wr_rate_i;
        rate_cnt_q <= '0;
        if (wr_target_i > cur_q)
          state_q <= CH_UP;
        else if (wr_target_i < cur_q)
          state_q <= CH_DOWN;
        else
          state_q <= CH_IDLE;
      end else if (tick_i && (state_q != CH_IDLE)) begin
        if (rate_cnt_q != '0) begin
          rate_cnt_q <= rate_cnt_q - RATE_W'(1);
        end else begin
          cur_q      <= step_d;
          rate_cnt_q <= rate_q;
          load_q     <= 1'b1;
`ifdef PWM_SEQ_BREATHE_EN
          if ((state_q == CH_UP) && (step_d == target_q))
            state_q <= CH_DOWN;
          else if ((state_q == CH_DOWN) && (step_d == '0))
            state_q <= (target_q == '0) ? CH_IDLE : CH_UP;
`else
          if (step_d == target_q)
            state_q <= CH_IDLE;
`endif
        end
      end
    end
  end

  assign duty_o = cur_q;
  assign load_o = load_q;
  assign busy_o = (state_q != CH_IDLE);

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Multi-channel duty fader: period counter, host config port and one pwm_seq_chan per channel.
// Define PWM_SEQ_BREATHE_EN to make channels breathe between 0 and target indefinitely.
module pwm_fade_sequencer
  import pwm_seq_pkg::*;
#(
  parameter  int R_SIZE = DEF_R_SIZE,
  parameter  int NCH    = DEF_NCH,
  parameter  int RATE_W = DEF_RATE_W,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [R_SIZE-1:0]     cfg_target,
  input  logic [RATE_W-1:0]     cfg_rate,
  output logic [NCH*R_SIZE-1:0] duty_o,
  output logic [NCH-1:0]        load_o,
  output logic [NCH-1:0]        busy_o,
  output logic                  period_tick_o
);

  logic [R_SIZE-1:0] pcnt_q;
  logic              cfg_fire;
  logic [NCH-1:0]    wr_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pcnt_q <= '0;
    else if (en)
      pcnt_q <= pcnt_q + R_SIZE'(1);
  end

  // Writes are refused only in the tick cycle so they never race a step.
  assign period_tick_o = en & (pcnt_q == '1);
  assign cfg_ready     = ~period_tick_o;
  assign cfg_fire      = cfg_valid & cfg_ready;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic [R_SIZE-1:0] duty;

    assign wr_sel[i] = cfg_fire & (cfg_ch == CH_W'(i));

    pwm_seq_chan #(
      .R_SIZE (R_SIZE),
      .RATE_W (RATE_W)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick_i      (period_tick_o),
      .wr_i        (wr_sel[i]),
      .wr_target_i (cfg_target),
      .wr_rate_i   (cfg_rate),
      .duty_o      (duty),
      .load_o      (load_o[i]),
      .busy_o      (busy_o[i])
    );

    assign duty_o[i*R_SIZE +: R_SIZE] = duty;
  end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Directed bench for pwm_fade_sequencer (R_SIZE=4): expected load events are queued by stimulus
// and popped by an independent monitor; define PWM_SEQ_BREATHE_EN to include the breathing run.
module tb_pwm_fade_sequencer;

  localparam int R_SIZE = 4;
  localparam int NCH    = 3;
  localparam int RATE_W = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  en = 1'b0;
  logic                  cfg_valid = 1'b0;
  logic                  cfg_ready;
  logic [1:0]            cfg_ch = '0;
  logic [R_SIZE-1:0]     cfg_target = '0;
  logic [RATE_W-1:0]     cfg_rate = '0;
  logic [NCH*R_SIZE-1:0] duty_o;
  logic [NCH-1:0]        load_o;
  logic [NCH-1:0]        busy_o;
  logic                  period_tick_o;

  typedef struct {
    int ch;
    int duty;
    int gap;
  } exp_t;

  exp_t sbQ[$];
  int   nChecks = 0;
  int   nPass = 0;
  int   cycle = 0;
  int   lastLoad[NCH];
  bit   prevTick = 1'b0;

  pwm_fade_sequencer #(
    .R_SIZE (R_SIZE),
    .NCH    (NCH),
    .RATE_W (RATE_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_ch        (cfg_ch),
    .cfg_target    (cfg_target),
    .cfg_rate      (cfg_rate),
    .duty_o        (duty_o),
    .load_o        (load_o),
    .busy_o        (busy_o),
    .period_tick_o (period_tick_o)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual == expected)
      nPass++;
    else
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
  endtask

  function automatic int chDuty(input int ch);
    return int'(duty_o[ch*R_SIZE +: R_SIZE]);
  endfunction

  task automatic pushExp(input int ch, input int duty, input int gap);
    exp_t e;
    e.ch   = ch;
    e.duty = duty;
    e.gap  = gap;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input int ch, input int target, input int rate);
    bit acc = 1'b0;
    @(negedge clk);
    cfg_valid  = 1'b1;
    cfg_ch     = ch[1:0];
    cfg_target = target[R_SIZE-1:0];
    cfg_rate   = rate[RATE_W-1:0];
    for (int k = 0; k < 20 && !acc; k++) begin
      acc = cfg_ready;
      @(posedge clk);
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    checkOutput("cfgAccept", int'(acc), 1);
  endtask

  task automatic waitLoads(input int ch, input int n, input int budget);
    int seen = 0;
    for (int k = 0; k < budget && seen < n; k++) begin
      @(negedge clk);
      if (load_o[ch]) seen++;
    end
    checkOutput("waitLoads", seen, n);
  endtask

  // Every load pulse must match the next queued expectation and follow a tick cycle.
  initial begin
    for (int i = 0; i < NCH; i++) lastLoad[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) begin
        if (load_o[i]) begin
          checkOutput("loadExpected", int'(sbQ.size() > 0), 1);
          if (sbQ.size() > 0) begin
            exp_t e;
            e = sbQ.pop_front();
            checkOutput("loadCh", i, e.ch);
            checkOutput("loadDuty", chDuty(i), e.duty);
            checkOutput("loadAlign", int'(prevTick), 1);
            if (e.gap != 0) checkOutput("loadGap", cycle - lastLoad[i], e.gap);
          end
          lastLoad[i] = cycle;
        end
      end
      prevTick = period_tick_o;
    end
  end

  initial begin
    bit found;
    int pauseTicks;
    int pauseLoads;
    int n;

    en = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rstDuty", int'(duty_o), 0);
    checkOutput("rstLoad", int'(load_o), 0);
    checkOutput("rstBusy", int'(busy_o), 0);
    checkOutput("rstTick", int'(period_tick_o), 0);
    checkOutput("rstReady", int'(cfg_ready), 1);
    rst_n = 1'b1;

    $display("[TB] basic ramp ch0 0->3 rate 0");
    pushExp(0, 1, 0); pushExp(0, 2, 16); pushExp(0, 3, 16);
    applyStimulus(0, 3, 0);
    checkOutput("busyAfterWr", int'(busy_o[0]), 1);
    waitLoads(0, 3, 80);
    repeat (20) @(negedge clk);
    checkOutput("basicBusy", int'(busy_o[0]), 0);
    checkOutput("basicDuty", chDuty(0), 3);

    $display("[TB] ramp rate ch1 0->2 rate 2");
    pushExp(1, 1, 0); pushExp(1, 2, 48);
    applyStimulus(1, 2, 2);
    waitLoads(1, 2, 100);
    repeat (20) @(negedge clk);
    checkOutput("rateBusy", int'(busy_o[1]), 0);
    checkOutput("rateDuty", chDuty(1), 2);

    $display("[TB] ch0 up to 5 then down to 2");
    pushExp(0, 4, 0); pushExp(0, 5, 16);
    applyStimulus(0, 5, 0);
    waitLoads(0, 2, 60);
    pushExp(0, 4, 0); pushExp(0, 3, 16); pushExp(0, 2, 16);
    applyStimulus(0, 2, 0);
    checkOutput("downBusy", int'(busy_o[0]), 1);
    waitLoads(0, 3, 80);
    repeat (20) @(negedge clk);
    checkOutput("downDuty", chDuty(0), 2);
    checkOutput("downIdle", int'(busy_o[0]), 0);

    $display("[TB] write held across a tick");
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (period_tick_o) found = 1'b1;
    end
    checkOutput("tickSeen", int'(found), 1);
    pushExp(2, 1, 0);
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_target = 4'd1; cfg_rate = 4'd0;
    checkOutput("readyInTick", int'(cfg_ready), 0);
    @(negedge clk);
    checkOutput("busyNotYet", int'(busy_o[2]), 0);
    checkOutput("readyAfterTick", int'(cfg_ready), 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    checkOutput("busyAccepted", int'(busy_o[2]), 1);
    waitLoads(2, 1, 40);

    $display("[TB] write to channel 3 is discarded");
    applyStimulus(3, 7, 0);
    checkOutput("badChBusy", int'(busy_o), 0);
    repeat (40) @(negedge clk);
    checkOutput("badChDuty", int'(duty_o), 12'h122);

    $display("[TB] pause ch0 ramp 2->6 for 40 cycles");
    pushExp(0, 3, 0); pushExp(0, 4, 56); pushExp(0, 5, 16); pushExp(0, 6, 16);
    applyStimulus(0, 6, 0);
    waitLoads(0, 1, 40);
    en = 1'b0;
    pauseTicks = 0;
    pauseLoads = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (period_tick_o) pauseTicks++;
      if (load_o != '0) pauseLoads++;
    end
    checkOutput("pauseTicks", pauseTicks, 0);
    checkOutput("pauseLoads", pauseLoads, 0);
    checkOutput("pauseDuty", chDuty(0), 3);
    checkOutput("pauseBusy", int'(busy_o[0]), 1);
    en = 1'b1;
    waitLoads(0, 3, 70);
    repeat (20) @(negedge clk);
    checkOutput("resumeDuty", chDuty(0), 6);

    $display("[TB] asynchronous reset mid-ramp");
    pushExp(1, 3, 0);
    applyStimulus(1, 9, 0);
    waitLoads(1, 1, 40);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("midRstDuty", int'(duty_o), 0);
    checkOutput("midRstLoad", int'(load_o), 0);
    checkOutput("midRstBusy", int'(busy_o), 0);
    checkOutput("midRstTick", int'(period_tick_o), 0);
    checkOutput("midRstReady", int'(cfg_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (period_tick_o) break;
    end
    checkOutput("pcntRestart", n, 15);

`ifdef PWM_SEQ_BREATHE_EN
    $display("[TB] breathing ch2 between 0 and 2");
    pushExp(2, 1, 0); pushExp(2, 2, 16); pushExp(2, 1, 16);
    pushExp(2, 0, 16); pushExp(2, 1, 16); pushExp(2, 2, 16);
    applyStimulus(2, 2, 0);
    waitLoads(2, 2, 40);
    checkOutput("breatheBusyPeak", int'(busy_o[2]), 1);
    waitLoads(2, 4, 80);
    pushExp(2, 1, 0); pushExp(2, 0, 16);
    applyStimulus(2, 0, 0);
    waitLoads(2, 2, 60);
    repeat (20) @(negedge clk);
    checkOutput("breatheEndBusy", int'(busy_o[2]), 0);
    checkOutput("breatheEndDuty", chDuty(2), 0);
`endif

    repeat (20) @(negedge clk);
    checkOutput("sbDrain", sbQ.size(), 0);
    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
